// File: rtl/nec_prefetch_pkg.sv
// Shared types and constants for the NEC instruction prefetch unit and its decoder.
// IPQ_SIZE must match the ipq[] depth seen by nec_decode.
package nec_prefetch_pkg;

  localparam int IPQ_SIZE    = 8;
  localparam int PHYS_ADDR_W = 20;

  typedef enum logic {
    PF_IDLE = 1'b0,
    PF_REQ  = 1'b1
  } prefetch_state_e;

  // Segment base plus word-aligned offset, wrapping naturally at 1 MiB.
  function automatic logic [PHYS_ADDR_W-1:0] fetch_phys_addr(
    input logic [15:0] seg,
    input logic [14:0] word_pc
  );
    return {seg, 4'h0} + {4'h0, word_pc, 1'b0};
  endfunction

endpackage

// File: rtl/nec_prefetch_if.sv
// Word-fetch bus between the prefetch unit (master) and the memory side (slave).
interface nec_prefetch_if;
  import nec_prefetch_pkg::*;

  logic                   fetch_req;
  logic [PHYS_ADDR_W-1:0] fetch_addr;
  logic                   fetch_ack;
  logic [15:0]            fetch_data;

  modport master (
    output fetch_req,
    output fetch_addr,
    input  fetch_ack,
    input  fetch_data
  );

  modport slave (
    input  fetch_req,
    input  fetch_addr,
    output fetch_ack,
    output fetch_data
  );

endinterface

// File: rtl/nec_prefetch.sv
// Instruction prefetch unit: fetches words from CS:fetch_pc into an 8-byte queue
// indexed by address low bits, exposed to the decoder relative to its pc.
module nec_prefetch
  import nec_prefetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                ce_1,
  input  logic                ce_2,
  input  logic [15:0]         cs,
  input  logic [15:0]         decode_pc,
  input  logic                set_pc,
  input  logic [15:0]         new_pc,
  input  logic                block_prefetch,
  nec_prefetch_if.master      bus,
  output logic [7:0]          ipq [IPQ_SIZE],
  output logic [3:0]          ipq_len
);

  prefetch_state_e        state, state_next;
  logic [15:0]            fetch_pc, fetch_pc_next;
  logic                   discard, discard_next;
  logic [PHYS_ADDR_W-1:0] addr_q, addr_next;
  logic                   enabled;
  logic                   ack_seen;
  logic                   wr_even, wr_odd;
  logic [4:0]             free, need;
  logic [2:0]             slot;

  assign enabled  = ce_1 | ce_2;
  assign ack_seen = ce_2 & bus.fetch_ack;
  assign ipq_len  = 4'(fetch_pc - decode_pc);
  assign free     = 5'(IPQ_SIZE) - {1'b0, ipq_len};
  assign need     = fetch_pc[0] ? 5'd1 : 5'd2;
  assign slot     = fetch_pc[2:0];

  assign bus.fetch_req  = (state == PF_REQ);
  assign bus.fetch_addr = addr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PF_IDLE;
      fetch_pc <= 16'h0000;
      discard  <= 1'b0;
      addr_q   <= '0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      discard  <= discard_next;
      addr_q   <= addr_next;
    end
  end

  // A redirect always wins the pointer; an in-flight word is dropped either by
  // ignoring a coincident ack or by marking the later ack for discard.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    discard_next  = discard;
    addr_next     = addr_q;
    wr_even       = 1'b0;
    wr_odd        = 1'b0;

    if (enabled) begin
      case (state)
        PF_IDLE: begin
          if (!set_pc && !block_prefetch && (free >= need)) begin
            state_next = PF_REQ;
            addr_next  = fetch_phys_addr(cs, fetch_pc[15:1]);
          end
        end
        PF_REQ: begin
          if (ack_seen) begin
            state_next   = PF_IDLE;
            discard_next = 1'b0;
            if (!set_pc && !discard) begin
              if (fetch_pc[0]) begin
                wr_odd        = 1'b1;
                fetch_pc_next = fetch_pc + 16'd1;
              end else begin
                wr_even       = 1'b1;
                fetch_pc_next = fetch_pc + 16'd2;
              end
            end
          end else if (set_pc) begin
            discard_next = 1'b1;
          end
        end
        default: state_next = PF_IDLE;
      endcase

      if (set_pc) begin
        fetch_pc_next = new_pc;
      end
    end
  end

  // Even fetches fill a slot pair; odd fetches only need the high byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < IPQ_SIZE; i++) begin
        ipq[i] <= 8'h00;
      end
    end else if (wr_even) begin
      ipq[slot]               <= bus.fetch_data[7:0];
      ipq[{slot[2:1], 1'b1}]  <= bus.fetch_data[15:8];
    end else if (wr_odd) begin
      ipq[slot] <= bus.fetch_data[15:8];
    end
  end

endmodule

// File: tb/tb_nec_prefetch.sv
// Testbench for nec_prefetch: directed scenarios plus randomized traffic against
// a byte-address reference model of the fetch stream.
module tb_nec_prefetch;
  import nec_prefetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, ce_1, ce_2, set_pc, block_prefetch;
  logic [15:0] cs, decode_pc, new_pc;
  logic [7:0]  ipq [IPQ_SIZE];
  logic [3:0]  ipq_len;

  int checks = 0;
  int errors = 0;

  // Reference model: next fetch address, outstanding request, and fetched bytes by address.
  int         m_pc;
  int         m_addr;
  bit         m_req;
  bit         m_disc;
  logic [7:0] m_bytes [int];

  nec_prefetch_if bus();

  nec_prefetch dut (
    .clk            (clk),
    .reset          (reset),
    .ce_1           (ce_1),
    .ce_2           (ce_2),
    .cs             (cs),
    .decode_pc      (decode_pc),
    .set_pc         (set_pc),
    .new_pc         (new_pc),
    .block_prefetch (block_prefetch),
    .bus            (bus),
    .ipq            (ipq),
    .ipq_len        (ipq_len)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int model_len();
    return (m_pc - int'(decode_pc)) & 32'hFFFF;
  endfunction

  task automatic model_step();
    int len;
    int need;
    bit ack;
    if (!(ce_1 || ce_2)) return;
    len  = model_len();
    need = (m_pc & 1) ? 1 : 2;
    ack  = ce_2 && bus.fetch_ack && m_req;
    if (m_req) begin
      if (ack) begin
        m_req = 1'b0;
        if (!set_pc && !m_disc) begin
          if (m_pc & 1) begin
            m_bytes[m_pc] = bus.fetch_data[15:8];
            m_pc = (m_pc + 1) & 32'hFFFF;
          end else begin
            m_bytes[m_pc] = bus.fetch_data[7:0];
            m_bytes[(m_pc + 1) & 32'hFFFF] = bus.fetch_data[15:8];
            m_pc = (m_pc + 2) & 32'hFFFF;
          end
        end
        m_disc = 1'b0;
        if (set_pc) m_pc = int'(new_pc);
      end else if (set_pc) begin
        m_pc   = int'(new_pc);
        m_disc = 1'b1;
      end
    end else if (set_pc) begin
      m_pc = int'(new_pc);
    end else if (!block_prefetch && (8 - len) >= need) begin
      m_req  = 1'b1;
      m_addr = (int'(cs) * 16 + (m_pc & 32'hFFFE)) & 32'hFFFFF;
    end
  endtask

  task automatic check_all();
    int len;
    int a;
    len = model_len();
    check_output("fetch_req", 32'(bus.fetch_req), 32'(m_req));
    check_output("fetch_addr", 32'(bus.fetch_addr), m_addr);
    check_output("ipq_len", 32'(ipq_len), len);
    for (int k = 0; k < len; k++) begin
      a = (int'(decode_pc) + k) & 32'hFFFF;
      if (m_bytes.exists(a)) check_output("ipq_byte", 32'(ipq[a & 7]), 32'(m_bytes[a]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_pc         = 1'b0;
    bus.fetch_ack  = 1'b0;
    decode_pc      = 16'h0000;
    block_prefetch = 1'b0;
    reset          = 1'b1;
    #1;
    m_pc   = 0;
    m_req  = 1'b0;
    m_disc = 1'b0;
    m_addr = 0;
    m_bytes.delete();
    check_all();
    for (int i = 0; i < IPQ_SIZE; i++) check_output("reset_ipq", 32'(ipq[i]), 32'h0);
    check_output("reset_discard", 32'(dut.discard), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic apply_stimulus(input logic [15:0] pc);
    set_pc    = 1'b1;
    new_pc    = pc;
    decode_pc = pc;
    tick();
    set_pc    = 1'b0;
  endtask

  task automatic wait_req(input string tag, input logic [19:0] exp_addr);
    bus.fetch_ack = 1'b0;
    for (int i = 0; i < 16 && !bus.fetch_req; i++) tick();
    check_output({tag, "_req"}, 32'(bus.fetch_req), 32'h1);
    check_output({tag, "_addr"}, 32'(bus.fetch_addr), 32'(exp_addr));
  endtask

  task automatic ack_word(input logic [15:0] d);
    bus.fetch_data = d;
    bus.fetch_ack  = 1'b1;
    tick();
    bus.fetch_ack  = 1'b0;
  endtask

  initial begin
    bit ph;
    int len;
    reset          = 1'b1;
    ce_1           = 1'b1;
    ce_2           = 1'b1;
    set_pc         = 1'b0;
    new_pc         = 16'h0000;
    block_prefetch = 1'b0;
    cs             = 16'h0000;
    decode_pc      = 16'h0000;
    bus.fetch_ack  = 1'b0;
    bus.fetch_data = 16'h0000;

    // Reset then fill the queue from 0xFFF0
    do_reset();
    cs = 16'hF000;
    apply_stimulus(16'hFFF0);
    wait_req("fill0", 20'hFFFF0); ack_word(16'h2211);
    wait_req("fill1", 20'hFFFF2); ack_word(16'h4433);
    wait_req("fill2", 20'hFFFF4); ack_word(16'h6655);
    wait_req("fill3", 20'hFFFF6); ack_word(16'h8877);
    repeat (4) tick();
    check_output("fill_no_5th_req", 32'(bus.fetch_req), 32'h0);
    check_output("fill_len", 32'(ipq_len), 32'h8);
    check_output("fill_ipq0", 32'(ipq[0]), 32'h11);
    check_output("fill_ipq7", 32'(ipq[7]), 32'h88);

    // Consume one byte: one free slot is not enough for an even fetch
    decode_pc = 16'hFFF1;
    repeat (3) tick();
    check_output("consume1_no_req", 32'(bus.fetch_req), 32'h0);
    decode_pc = 16'hFFF2;
    wait_req("refill", 20'hFFFF8);
    ack_word(16'hAA99);
    check_output("refill_len", 32'(ipq_len), 32'h8);
    check_output("refill_ipq1", 32'(ipq[1]), 32'hAA);

    // Odd start fetches the containing word and keeps only the high byte
    do_reset();
    cs = 16'h0000;
    apply_stimulus(16'h0103);
    wait_req("odd", 20'h00102);
    ack_word(16'hAB12);
    check_output("odd_ipq3", 32'(ipq[3]), 32'hAB);
    check_output("odd_len", 32'(ipq_len), 32'h1);
    wait_req("odd_next", 20'h00104);

    // Flush while a request is outstanding
    apply_stimulus(16'h0200);
    check_output("flush_discard", 32'(dut.discard), 32'h1);
    tick();
    ack_word(16'hDEAD);
    check_output("flush_len", 32'(ipq_len), 32'h0);
    check_output("flush_discard_clr", 32'(dut.discard), 32'h0);
    wait_req("flush_next", 20'h00200);

    // Redirect coinciding with the ack
    set_pc = 1'b1; new_pc = 16'h0300; decode_pc = 16'h0300;
    bus.fetch_data = 16'hBEEF; bus.fetch_ack = 1'b1;
    tick();
    set_pc = 1'b0; bus.fetch_ack = 1'b0;
    check_output("coinc_req", 32'(bus.fetch_req), 32'h0);
    check_output("coinc_len", 32'(ipq_len), 32'h0);
    check_output("coinc_discard", 32'(dut.discard), 32'h0);
    tick();
    check_output("coinc_next_req", 32'(bus.fetch_req), 32'h1);
    check_output("coinc_next_addr", 32'(bus.fetch_addr), 32'h00300);

    // block_prefetch, then 16-bit pc wrap
    do_reset();
    cs = 16'h1000;
    block_prefetch = 1'b1;
    apply_stimulus(16'hFFFE);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_output("blocked_no_req", 32'(bus.fetch_req), 32'h0);
    end
    block_prefetch = 1'b0;
    wait_req("wrap0", 20'h1FFFE);
    ack_word(16'h5566);
    check_output("wrap_len", 32'(ipq_len), 32'h2);
    wait_req("wrap1", 20'h10000);

    // Reset with the request still outstanding
    do_reset();

    // Randomized traffic with split phase enables
    ph = 1'b0;
    cs = 16'($urandom);
    apply_stimulus(16'($urandom));
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
        cs = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) begin
        ce_1 = 1'b0; ce_2 = 1'b0;
      end else begin
        ce_1 = ph; ce_2 = !ph; ph = !ph;
      end
      bus.fetch_ack  = m_req && ce_2 && ($urandom_range(0, 2) == 0);
      bus.fetch_data = 16'($urandom);
      len = model_len();
      if ((ce_1 || ce_2) && $urandom_range(0, 39) == 0) begin
        set_pc    = 1'b1;
        new_pc    = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFF8, 16'hFFFF)) : 16'($urandom);
        decode_pc = new_pc;
      end else begin
        set_pc = 1'b0;
        if (len > 0) decode_pc = decode_pc + 16'($urandom_range(0, (len > 2) ? 2 : len));
      end
      if ($urandom_range(0, 15) == 0) block_prefetch = !block_prefetch;
      if ($urandom_range(0, 63) == 0) cs = 16'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
